// File: rtl/byte_serializer.sv
// byte_serializer: accepts one byte per valid/ready handshake and shifts it
// out one bit per clock on out_data, MSB or LSB first (MSB_FIRST).
//
// Optional build macro SERIALIZER_PARITY_EN: when defined, every frame gets
// a ninth cycle carrying the even-parity bit (XOR of the captured byte).
//
// Handshake: a byte transfers on a rising Clk edge where in_valid=1 and
// in_ready=1. in_ready is 1 in IDLE and in the final frame cycle, so a
// byte offered during the final cycle starts the next frame with no gap.
// in_byte is sampled only on that edge; later changes do not affect the frame.
//
// All outputs are registered and reflect the cycle being entered. dbg_state
// mirrors the FSM state (IDLE=0, SHIFT=1, PARITY=2).
module byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_data,
  output logic       out_valid,
  output logic       frame_done,
  output logic       busy,
  output logic [1:0] dbg_state
);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t     state;
  logic [2:0] cnt;       // position of the bit currently on out_data
  logic [7:0] hold;      // byte captured at the accepting edge
  logic       accept;

  assign accept    = in_valid & in_ready;
  assign dbg_state = state;

  // Bit at frame position idx, honouring the configured bit order.
  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
    return MSB_FIRST ? b[3'd7 - idx] : b[idx];
  endfunction

  // Frame FSM with registered outputs; an accept always starts a fresh frame.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      hold       <= 8'h00;
      in_ready   <= 1'b1;
      out_data   <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      cnt        <= 3'd0;
      hold       <= in_byte;
      out_data   <= pick_bit(in_byte, 3'd0);
      out_valid  <= 1'b1;
      busy       <= 1'b1;
      in_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_data   <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          in_ready   <= 1'b1;
        end
        SHIFT: begin
          cnt <= cnt + 3'd1;  // wraps 7 -> 0 at the end of the data bits
          if (cnt == 3'd7) begin
`ifdef SERIALIZER_PARITY_EN
            state      <= PARITY;
            out_data   <= ^hold;
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            frame_done <= 1'b1;
            in_ready   <= 1'b1;
`else
            // last bit shown with no follow-on byte: drop back to idle
            state      <= IDLE;
            out_data   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b1;
`endif
          end else begin
            out_data <= pick_bit(hold, cnt + 3'd1);
`ifndef SERIALIZER_PARITY_EN
            // entering the 8th bit: it is the final frame cycle
            frame_done <= (cnt == 3'd6);
            in_ready   <= (cnt == 3'd6);
`endif
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          state      <= IDLE;
          out_data   <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          in_ready   <= 1'b1;
        end
`endif
        default: begin
          state      <= IDLE;
          cnt        <= 3'd0;
          out_data   <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: drives an MSB-first and an LSB-first instance with the
// same inputs and compares both against a queue-based frame model, a table
// of known byte patterns, and hand-written back-to-back / reset sequences.
module tb_byte_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;

  always #5 Clk = ~Clk;

  logic       m_in_ready, m_out_data, m_out_valid, m_frame_done, m_busy;
  logic       l_in_ready, l_out_data, l_out_valid, l_frame_done, l_busy;
  logic [1:0] m_dbg_state, l_dbg_state;

  byte_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .Clk(Clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
    .frame_done(m_frame_done), .busy(m_busy), .dbg_state(m_dbg_state)
  );

  byte_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .Clk(Clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(l_in_ready), .out_data(l_out_data), .out_valid(l_out_valid),
    .frame_done(l_frame_done), .busy(l_busy), .dbg_state(l_dbg_state)
  );

  // observed vector: {in_ready, out_valid, out_data, frame_done, busy}
  logic [4:0] msb_obs, lsb_obs;
  assign msb_obs = {m_in_ready, m_out_valid, m_out_data, m_frame_done, m_busy};
  assign lsb_obs = {l_in_ready, l_out_valid, l_out_data, l_frame_done, l_busy};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  // pending frame bits, head = bit on out_data in the current cycle
  logic [0:0] exp_msb_q[$];
  logic [0:0] exp_lsb_q[$];

  task automatic check_vec(input string name, input logic [4:0] got, input logic [4:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b (ready,valid,data,done,busy) t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [4:0] model_exp(input bit msb);
    int n;
    logic d;
    n = msb ? exp_msb_q.size() : exp_lsb_q.size();
    d = 1'b0;
    if (n > 0) d = msb ? exp_msb_q[0][0] : exp_lsb_q[0][0];
    return {(n <= 1), (n > 0), d, (n == 1), (n > 0)};
  endfunction

  // One rising edge of the reference: retire the shown bit, then load a new
  // frame if the byte was offered while the block could take it.
  task automatic model_edge(input logic v, input logic [7:0] b);
    bit rdy;
    rdy = (exp_msb_q.size() <= 1);
    if (exp_msb_q.size() > 0) begin
      void'(exp_msb_q.pop_front());
      void'(exp_lsb_q.pop_front());
    end
    if (v && rdy) begin
      for (int i = 0; i < 8; i++) begin
        exp_msb_q.push_back(b[7 - i]);
        exp_lsb_q.push_back(b[i]);
      end
`ifdef SERIALIZER_PARITY_EN
      exp_msb_q.push_back(^b);
      exp_lsb_q.push_back(^b);
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [7:0] b);
    in_valid = v;
    in_byte  = b;
    @(posedge Clk);
    model_edge(v, b);
    @(negedge Clk);
    check_vec("model_msb", msb_obs, model_exp(1'b1));
    check_vec("model_lsb", lsb_obs, model_exp(1'b0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] din;
    logic [7:0] msb_seq;  // emission order, first bit at [7]
    logic [7:0] lsb_seq;  // emission order, first bit at [7]
    logic       par;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hB4, 8'b10110100, 8'b00101101, 1'b0};
    tbl[1] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
    tbl[2] = '{8'h03, 8'b00000011, 8'b11000000, 1'b0};
    tbl[3] = '{8'h81, 8'b10000001, 8'b10000001, 1'b0};
    tbl[4] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
    tbl[5] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
    tbl[6] = '{8'hFF, 8'b11111111, 8'b11111111, 1'b0};

    // reset asserted away from any edge: outputs must follow immediately
    #2 reset = 1'b0;
    #1;
    check_vec("reset_msb", msb_obs, 5'b10000);
    check_vec("reset_lsb", lsb_obs, 5'b10000);
    check_int("reset_state", int'(m_dbg_state), 0);
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b1;

    // idle with in_valid low
    for (int i = 0; i < 12; i++) step(1'b0, 8'($urandom));

    // table: single-pulse frames with known bit sequences
    for (int t = 0; t < 7; t++) begin
      step(1'b1, tbl[t].din);
      for (int i = 0; i < FRAME_LEN; i++) begin
        logic em, el;
        bit   last;
        last = (i == FRAME_LEN - 1);
        if (i < 8) begin
          em = tbl[t].msb_seq[7 - i];
          el = tbl[t].lsb_seq[7 - i];
        end else begin
          em = tbl[t].par;
          el = tbl[t].par;
        end
        check_vec("tbl_msb", msb_obs, {last, 1'b1, em, last, 1'b1});
        check_vec("tbl_lsb", lsb_obs, {last, 1'b1, el, last, 1'b1});
        if (!last) step(1'b0, 8'($urandom));
      end
      step(1'b0, 8'($urandom));
      check_vec("tbl_idle", msb_obs, 5'b10000);
    end

    // back-to-back: valid held high, second byte offered in the final cycle
    begin
      int nv, nd, d0, d1;
      nv = 0; nd = 0; d0 = -1; d1 = -1;
      step(1'b1, 8'hA5);
      for (int j = 0; j < 2 * FRAME_LEN; j++) begin
        if (m_out_valid) nv++;
        if (m_frame_done) begin
          if (nd == 0) d0 = j; else d1 = j;
          nd++;
        end
        if (j < FRAME_LEN - 1) step(1'b1, 8'hA5);
        else if (j == FRAME_LEN - 1) step(1'b1, 8'h3C);
        else step(1'b0, 8'h00);
      end
      check_int("b2b_valid_cycles", nv, 2 * FRAME_LEN);
      check_int("b2b_done_count", nd, 2);
      check_int("b2b_done_spacing", d1 - d0, FRAME_LEN);
    end

    // input changes after acceptance must not disturb the frame
    begin
      logic [7:0] gm, gl;
      gm = 8'h00; gl = 8'h00;
      step(1'b1, 8'h81);
      for (int j = 0; j < FRAME_LEN; j++) begin
        if (j < 8) begin
          gm[7 - j] = m_out_data;
          gl[7 - j] = l_out_data;
        end
        step((j < FRAME_LEN - 1) ? 1'b1 : 1'b0, 8'h00);
      end
      check_int("hold_msb_bits", int'(gm), int'(8'b10000001));
      check_int("hold_lsb_bits", int'(gl), int'(8'b10000001));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);

    // asynchronous reset in the middle of a frame (4th bit of 8'hFF)
    step(1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    check_vec("pre_reset_4th_bit", msb_obs, 5'b01101);
    #2 reset = 1'b0;
    #1;
    check_vec("midreset_msb", msb_obs, 5'b10000);
    check_vec("midreset_lsb", lsb_obs, 5'b10000);
    check_int("midreset_state", int'(l_dbg_state), 0);
    exp_msb_q.delete();
    exp_lsb_q.delete();
    @(posedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    for (int i = 0; i < FRAME_LEN + 2; i++) step(1'b0, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < FRAME_LEN + 2; i++) step(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
